pl_alu_seq: RTL and testbench

Parametrised, handshaked successor to the EX-stage ALU of the 8-bit RISC pipeline. Accepts one operation per transaction over a valid/ready interface, executes single-cycle ops in one cycle and variable-distance shifts (and, optionally, multiply) iteratively over several cycles. Holds the result and flags in an output register until the consumer takes them. Sits between the ID/EX register and the EX/MEM register and stalls the pipeline through `in_ready`.

---
 rtl/pl_alu_pkg.sv | 57 +++++
 rtl/pl_alu_seq_if.sv | 39 +++
 rtl/pl_alu_iter.sv | 122 ++++++++++++
 rtl/pl_alu_seq.sv | 201 ++++++++++++++++++++
 tb/tb_pl_alu_seq.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/pl_alu_pkg.sv
// Shared opcode, FSM-state and flag types for the pipelined ALU; PL_ALU_MUL_EN enables opcode 13 (MUL).
// Latency: none, types and helper only.
// Backpressure: none, types and helper only.
package pl_alu_pkg;

  localparam int OPC_W = 4;

  typedef enum logic [OPC_W-1:0] {
    OP_ADD   = 4'd0,
    OP_ADDC  = 4'd1,
    OP_SUB   = 4'd2,
    OP_CMP   = 4'd3,
    OP_AND   = 4'd4,
    OP_OR    = 4'd5,
    OP_LAND  = 4'd6,
    OP_LOR   = 4'd7,
    OP_NOT   = 4'd8,
    OP_LNOT  = 4'd9,
    OP_SHL   = 4'd10,
    OP_SHR   = 4'd11,
    OP_STORE = 4'd12,
    OP_MUL   = 4'd13,
    OP_ILL14 = 4'd14,
    OP_ILL15 = 4'd15
  } alu_op_e;

  typedef enum logic {
    IDLE = 1'b0,
    ITER = 1'b1
  } alu_state_e;

  // Flag bundle held in the output register next to the result.
  typedef struct packed {
    logic cout;
    logic zero;
    logic gt;
    logic lt;
    logic eq;
    logic illegal;
  } alu_flags_t;

  // True when an accepted op must go through the iterative datapath.
  // Zero-distance shifts complete in the single-cycle path instead.
  function automatic logic op_needs_iter(alu_op_e op, logic shamt_nz);
    logic r;
    r = 1'b0;
    case (op)
      OP_SHL, OP_SHR: r = shamt_nz;
`ifdef PL_ALU_MUL_EN
      OP_MUL:         r = 1'b1;
`endif
      default:        r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/pl_alu_seq_if.sv
// Operation/result handshake bundle between the ID/EX producer, the ALU and the EX/MEM consumer.
// Latency: none, wiring only.
// Backpressure: in_ready stalls the producer, out_ready stalls the ALU result register.
interface pl_alu_seq_if
  import pl_alu_pkg::*;
#(
  parameter int WIDTH = 8
);

  logic             in_valid;
  logic             in_ready;
  logic [OPC_W-1:0] op;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] dout;
  logic [WIDTH-1:0] dout_hi;
  logic             cout;
  logic             zero;
  logic             gt;
  logic             lt;
  logic             eq;
  logic             illegal;

  // Pipeline side: presents operations and consumes results.
  modport master (
    output in_valid, op, op1, op2, cin, out_ready,
    input  in_ready, out_valid, dout, dout_hi, cout, zero, gt, lt, eq, illegal
  );

  // ALU side.
  modport slave (
    input  in_valid, op, op1, op2, cin, out_ready,
    output in_ready, out_valid, dout, dout_hi, cout, zero, gt, lt, eq, illegal
  );

endinterface

// File: rtl/pl_alu_iter.sv
// Iterative datapath: logical shifts one bit per cycle and (PL_ALU_MUL_EN) unsigned shift-add multiply.
// Latency: n cycles after start for a shift by n, WIDTH cycles for MUL; done marks the final step.
// Backpressure: none; the caller only starts it when the result register will be free on completion.
module pl_alu_iter
  import pl_alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_vld,
  input  alu_op_e          start_op,
  input  logic [WIDTH-1:0] start_op1,
  input  logic [WIDTH-1:0] start_op2,
  output logic             done,
  output logic [WIDTH-1:0] res_dat,
`ifdef PL_ALU_MUL_EN
  output logic [WIDTH-1:0] res_hi_dat,
`endif
  output logic             res_cout
);

  // Counter must hold WIDTH itself for MUL, hence one bit wider than the shift amount.
  localparam int CW = SHW + 1;

  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;   // shift operand, or multiplier / low product for MUL
  logic             left_q, left_d;
  logic [WIDTH-1:0] step_acc;
  logic             step_cout;

`ifdef PL_ALU_MUL_EN
  logic             mul_q, mul_d;
  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH:0]   psum;
`else
  logic [WIDTH-SHW-1:0] unused_op2_hi;
  assign unused_op2_hi = start_op2[WIDTH-1:SHW];
`endif

  // One iteration step computed from the working registers.
  always_comb begin
    step_acc  = left_q ? {acc_q[WIDTH-2:0], 1'b0} : {1'b0, acc_q[WIDTH-1:1]};
    step_cout = left_q ? acc_q[WIDTH-1] : acc_q[0];
`ifdef PL_ALU_MUL_EN
    psum    = {1'b0, hi_q} + (acc_q[0] ? {1'b0, mcand_q} : {(WIDTH+1){1'b0}});
    step_hi = psum[WIDTH:1];
    if (mul_q) begin
      // Partial product shifts right into the multiplier register.
      step_acc  = {psum[0], acc_q[WIDTH-1:1]};
      step_cout = 1'b0;
    end
`endif
  end

  // Load on start, otherwise step and count down while busy.
  always_comb begin
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    left_d = left_q;
`ifdef PL_ALU_MUL_EN
    mul_d   = mul_q;
    mcand_d = mcand_q;
    hi_d    = hi_q;
`endif
    if (start_vld) begin
      left_d = (start_op == OP_SHL);
      acc_d  = start_op1;
      cnt_d  = {1'b0, start_op2[SHW-1:0]};
`ifdef PL_ALU_MUL_EN
      mul_d   = (start_op == OP_MUL);
      mcand_d = start_op1;
      hi_d    = '0;
      if (start_op == OP_MUL) begin
        acc_d = start_op2;
        cnt_d = CW'(WIDTH);
      end
`endif
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CW'(1);
      acc_d = step_acc;
`ifdef PL_ALU_MUL_EN
      hi_d  = step_hi;
`endif
    end
  end

  // Working registers; reset discards any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      acc_q  <= '0;
      left_q <= 1'b0;
`ifdef PL_ALU_MUL_EN
      mul_q   <= 1'b0;
      mcand_q <= '0;
      hi_q    <= '0;
`endif
    end else begin
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      left_q <= left_d;
`ifdef PL_ALU_MUL_EN
      mul_q   <= mul_d;
      mcand_q <= mcand_d;
      hi_q    <= hi_d;
`endif
    end
  end

  // The final step's value is handed straight to the output register.
  assign done     = (cnt_q == CW'(1));
  assign res_dat  = step_acc;
  assign res_cout = step_cout;
`ifdef PL_ALU_MUL_EN
  assign res_hi_dat = step_hi;
`endif

endmodule

// File: rtl/pl_alu_seq.sv
// Handshaked EX-stage ALU; PL_ALU_MUL_EN adds an iterative unsigned multiplier on opcode 13.
// Latency: 1 for single-cycle ops and zero shifts, n+1 for shift by n, WIDTH+1 for MUL.
// Backpressure: in_ready low while iterating or while a held result is not being consumed.
module pl_alu_seq
  import pl_alu_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic         clk,
  input logic         rst_n,
  pl_alu_seq_if.slave bus
);

  localparam int SHW = $clog2(WIDTH);

  alu_state_e       state_q, state_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  alu_flags_t       flags_q, flags_d;
`ifdef PL_ALU_MUL_EN
  logic [WIDTH-1:0] dout_hi_q, dout_hi_d;
  logic [WIDTH-1:0] it_res_hi;
`endif

  alu_op_e          op;
  logic [SHW-1:0]   shamt;
  logic             load_ok;
  logic             in_ready;
  logic             accept;
  logic             go_iter;

  logic             it_done;
  logic [WIDTH-1:0] it_res;
  logic             it_cout;
  logic             it_zero;

  logic [WIDTH:0]   add_sum;
  logic [WIDTH:0]   sub_dif;
  logic [WIDTH-1:0] sc_dout;
  logic             sc_cout;
  logic             sc_gt;
  logic             sc_lt;
  logic             sc_eq;
  logic             sc_ill;

  assign op       = alu_op_e'(bus.op);
  assign shamt    = bus.op2[SHW-1:0];
  assign load_ok  = !out_valid_q || bus.out_ready;
  assign in_ready = (state_q == IDLE) && load_ok;
  assign accept   = bus.in_valid && in_ready;
  assign go_iter  = accept && op_needs_iter(op, shamt != '0);

  // Single-cycle datapath, evaluated on the live operands during the accept cycle.
  always_comb begin
    add_sum = {1'b0, bus.op1} + {1'b0, bus.op2}
            + {{WIDTH{1'b0}}, (op == OP_ADDC) && bus.cin};
    sub_dif = {1'b0, bus.op1} + {1'b0, ~bus.op2} + {{WIDTH{1'b0}}, 1'b1};
    sc_dout = '0;
    sc_cout = 1'b0;
    sc_gt   = 1'b0;
    sc_lt   = 1'b0;
    sc_eq   = 1'b0;
    sc_ill  = 1'b0;
    case (op)
      OP_ADD, OP_ADDC: begin
        sc_dout = add_sum[WIDTH-1:0];
        sc_cout = add_sum[WIDTH];
      end
      OP_SUB: begin
        sc_dout = sub_dif[WIDTH-1:0];
        sc_cout = sub_dif[WIDTH];
      end
      OP_CMP: begin
        sc_dout = sub_dif[WIDTH-1:0];
        sc_cout = sub_dif[WIDTH];
        sc_gt   = bus.op1 > bus.op2;
        sc_lt   = bus.op1 < bus.op2;
        sc_eq   = bus.op1 == bus.op2;
      end
      OP_AND:   sc_dout = bus.op1 & bus.op2;
      OP_OR:    sc_dout = bus.op1 | bus.op2;
      OP_LAND:  sc_dout = {{(WIDTH-1){1'b0}}, (|bus.op1) && (|bus.op2)};
      OP_LOR:   sc_dout = {{(WIDTH-1){1'b0}}, (|bus.op1) || (|bus.op2)};
      OP_NOT:   sc_dout = ~bus.op1;
      OP_LNOT:  sc_dout = {{(WIDTH-1){1'b0}}, ~|bus.op1};
      // Only reached for zero-distance shifts: operand passes through, nothing shifted out.
      OP_SHL, OP_SHR: sc_dout = bus.op1;
      OP_STORE: sc_dout = bus.op1;
`ifdef PL_ALU_MUL_EN
      OP_MUL:   sc_dout = '0;
`endif
      default:  sc_ill = 1'b1;
    endcase
  end

`ifdef PL_ALU_MUL_EN
  assign it_zero = (it_res == '0) && (it_res_hi == '0);
`else
  assign it_zero = (it_res == '0);
`endif

  // FSM next state and output-register load.
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    dout_d      = dout_q;
    flags_d     = flags_q;
`ifdef PL_ALU_MUL_EN
    dout_hi_d   = dout_hi_q;
`endif
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end
    case (state_q)
      IDLE: begin
        if (accept) begin
          if (go_iter) begin
            state_d = ITER;
          end else begin
            out_valid_d = 1'b1;
            dout_d      = sc_dout;
`ifdef PL_ALU_MUL_EN
            dout_hi_d   = '0;
`endif
            flags_d = '{cout: sc_cout, zero: !sc_ill && (sc_dout == '0),
                        gt: sc_gt, lt: sc_lt, eq: sc_eq, illegal: sc_ill};
          end
        end
      end
      ITER: begin
        // The register is necessarily free here: entry into ITER consumed or found it empty.
        if (it_done) begin
          state_d     = IDLE;
          out_valid_d = 1'b1;
          dout_d      = it_res;
`ifdef PL_ALU_MUL_EN
          dout_hi_d   = it_res_hi;
`endif
          flags_d = '{cout: it_cout, zero: it_zero,
                      gt: 1'b0, lt: 1'b0, eq: 1'b0, illegal: 1'b0};
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      dout_q      <= '0;
      flags_q     <= '0;
`ifdef PL_ALU_MUL_EN
      dout_hi_q   <= '0;
`endif
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      dout_q      <= dout_d;
      flags_q     <= flags_d;
`ifdef PL_ALU_MUL_EN
      dout_hi_q   <= dout_hi_d;
`endif
    end
  end

  pl_alu_iter #(
    .WIDTH (WIDTH),
    .SHW   (SHW)
  ) u_iter (
    .clk        (clk),
    .rst_n      (rst_n),
    .start_vld  (go_iter),
    .start_op   (op),
    .start_op1  (bus.op1),
    .start_op2  (bus.op2),
    .done       (it_done),
    .res_dat    (it_res),
`ifdef PL_ALU_MUL_EN
    .res_hi_dat (it_res_hi),
`endif
    .res_cout   (it_cout)
  );

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.dout      = dout_q;
`ifdef PL_ALU_MUL_EN
  assign bus.dout_hi   = dout_hi_q;
`else
  assign bus.dout_hi   = '0;
`endif
  assign bus.cout      = flags_q.cout;
  assign bus.zero      = flags_q.zero;
  assign bus.gt        = flags_q.gt;
  assign bus.lt        = flags_q.lt;
  assign bus.eq        = flags_q.eq;
  assign bus.illegal   = flags_q.illegal;

endmodule

// File: tb/tb_pl_alu_seq.sv
// Bench for pl_alu_seq at WIDTH=8: directed table, backpressure/reset sequences, random ops vs model.
// Latency: checked per operation in cycles from accept to out_valid.
// Backpressure: out_ready is held low in dedicated and random stretches.
module tb_pl_alu_seq;
  import pl_alu_pkg::*;

  localparam int W = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  pl_alu_seq_if #(.WIDTH(W)) bus ();

  pl_alu_seq #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  typedef struct {
    string      name;
    logic [3:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic       c;
    logic [7:0] dout;
    logic [7:0] hi;
    logic [5:0] fl;   // cout, zero, gt, lt, eq, illegal
    int         lat;
  } vec_t;

  vec_t vt[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] observe();
    return {10'd0, bus.dout_hi, bus.dout, bus.cout, bus.zero,
            bus.gt, bus.lt, bus.eq, bus.illegal};
  endfunction

  function automatic vec_t mk(string nm, logic [3:0] o, logic [7:0] a, logic [7:0] b,
                              logic c, logic [7:0] d, logic [7:0] h, logic [5:0] f, int l);
    vec_t v;
    v.name = nm; v.op = o; v.a = a; v.b = b; v.c = c;
    v.dout = d; v.hi = h; v.fl = f; v.lat = l;
    return v;
  endfunction

  // Reference: plain integer arithmetic straight from the opcode definitions.
  function automatic logic [31:0] model(input logic [3:0] o, input int a, input int b,
                                        input int c, output int lat);
    int r, hi, co, z, g, l, e, il, n, p;
    r = 0; hi = 0; co = 0; g = 0; l = 0; e = 0; il = 0; lat = 1; n = b % 8;
    case (o)
      OP_ADD:   begin r = a + b; co = r / 256; r = r % 256; end
      OP_ADDC:  begin r = a + b + c; co = r / 256; r = r % 256; end
      OP_SUB:   begin r = (a - b) & 255; co = (a >= b) ? 1 : 0; end
      OP_CMP:   begin
        r = (a - b) & 255; co = (a >= b) ? 1 : 0;
        g = (a > b) ? 1 : 0; l = (a < b) ? 1 : 0; e = (a == b) ? 1 : 0;
      end
      OP_AND:   r = a & b;
      OP_OR:    r = a | b;
      OP_LAND:  r = (a != 0 && b != 0) ? 1 : 0;
      OP_LOR:   r = (a != 0 || b != 0) ? 1 : 0;
      OP_NOT:   r = (~a) & 255;
      OP_LNOT:  r = (a == 0) ? 1 : 0;
      OP_SHL:   begin r = (a << n) & 255; co = (n != 0) ? ((a >> (8 - n)) & 1) : 0; lat = n + 1; end
      OP_SHR:   begin r = a >> n; co = (n != 0) ? ((a >> (n - 1)) & 1) : 0; lat = n + 1; end
      OP_STORE: r = a;
`ifdef PL_ALU_MUL_EN
      OP_MUL:   begin p = a * b; r = p % 256; hi = p / 256; lat = 9; end
`endif
      default:  il = 1;
    endcase
    z = (il == 0 && r == 0 && hi == 0) ? 1 : 0;
    return 32'(hi * 16384 + r * 64 + co * 32 + z * 16 + g * 8 + l * 4 + e * 2 + il);
  endfunction

  // Present one op, scramble the inputs after accept, wait (bounded) for the result.
  task automatic run_op(input logic [3:0] o, input logic [7:0] a, input logic [7:0] b,
                        input logic c, output logic [31:0] obs, output int lat,
                        output int rdy_low);
    int t;
    t = 0;
    while (!bus.in_ready && t < 50) begin
      cyc();
      t++;
    end
    if (!bus.in_ready) check("in_ready wait", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b1;
    bus.op  = o;
    bus.op1 = a;
    bus.op2 = b;
    bus.cin = c;
    cyc();
    bus.in_valid = 1'b0;
    bus.op  = 4'($urandom);
    bus.op1 = 8'($urandom);
    bus.op2 = 8'($urandom);
    bus.cin = 1'($urandom);
    lat = 1;
    rdy_low = 0;
    while (!bus.out_valid && lat < 40) begin
      if (!bus.in_ready) rdy_low++;
      cyc();
      lat++;
    end
    obs = observe();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] obs;
    logic [31:0] exp;
    int lat, rl, mlat, seen;

    vt.push_back(mk("add_f0_20",   OP_ADD,   8'hF0, 8'h20, 1'b0, 8'h10, 8'h00, 6'b100000, 1));
    vt.push_back(mk("addc_7f_00",  OP_ADDC,  8'h7F, 8'h00, 1'b1, 8'h80, 8'h00, 6'b000000, 1));
    vt.push_back(mk("add_ff_01",   OP_ADD,   8'hFF, 8'h01, 1'b1, 8'h00, 8'h00, 6'b110000, 1));
    vt.push_back(mk("sub_05_07",   OP_SUB,   8'h05, 8'h07, 1'b0, 8'hFE, 8'h00, 6'b000000, 1));
    vt.push_back(mk("sub_07_05",   OP_SUB,   8'h07, 8'h05, 1'b0, 8'h02, 8'h00, 6'b100000, 1));
    vt.push_back(mk("cmp_05_07",   OP_CMP,   8'h05, 8'h07, 1'b0, 8'hFE, 8'h00, 6'b000100, 1));
    vt.push_back(mk("cmp_42_42",   OP_CMP,   8'h42, 8'h42, 1'b0, 8'h00, 8'h00, 6'b110010, 1));
    vt.push_back(mk("cmp_09_03",   OP_CMP,   8'h09, 8'h03, 1'b0, 8'h06, 8'h00, 6'b101000, 1));
    vt.push_back(mk("and_cc_aa",   OP_AND,   8'hCC, 8'hAA, 1'b0, 8'h88, 8'h00, 6'b000000, 1));
    vt.push_back(mk("or_cc_aa",    OP_OR,    8'hCC, 8'hAA, 1'b0, 8'hEE, 8'h00, 6'b000000, 1));
    vt.push_back(mk("not_0f",      OP_NOT,   8'h0F, 8'h55, 1'b0, 8'hF0, 8'h00, 6'b000000, 1));
    vt.push_back(mk("land_10_00",  OP_LAND,  8'h10, 8'h00, 1'b0, 8'h00, 8'h00, 6'b010000, 1));
    vt.push_back(mk("lor_00_01",   OP_LOR,   8'h00, 8'h01, 1'b0, 8'h01, 8'h00, 6'b000000, 1));
    vt.push_back(mk("lnot_00",     OP_LNOT,  8'h00, 8'h00, 1'b0, 8'h01, 8'h00, 6'b000000, 1));
    vt.push_back(mk("lnot_03",     OP_LNOT,  8'h03, 8'h00, 1'b0, 8'h00, 8'h00, 6'b010000, 1));
    vt.push_back(mk("store_5a",    OP_STORE, 8'h5A, 8'h33, 1'b0, 8'h5A, 8'h00, 6'b000000, 1));
    vt.push_back(mk("shl_81_3",    OP_SHL,   8'h81, 8'h03, 1'b0, 8'h08, 8'h00, 6'b000000, 4));
    vt.push_back(mk("shr_81_1",    OP_SHR,   8'h81, 8'h01, 1'b0, 8'h40, 8'h00, 6'b100000, 2));
    vt.push_back(mk("shl_81_0",    OP_SHL,   8'h81, 8'h00, 1'b0, 8'h81, 8'h00, 6'b000000, 1));
    vt.push_back(mk("shr_80_7",    OP_SHR,   8'h80, 8'h07, 1'b0, 8'h01, 8'h00, 6'b000000, 8));
    vt.push_back(mk("shl_ff_7",    OP_SHL,   8'hFF, 8'h07, 1'b0, 8'h80, 8'h00, 6'b100000, 8));
`ifdef PL_ALU_MUL_EN
    vt.push_back(mk("mul_ff_ff",   OP_MUL,   8'hFF, 8'hFF, 1'b0, 8'h01, 8'hFE, 6'b000000, 9));
    vt.push_back(mk("mul_00_37",   OP_MUL,   8'h00, 8'h37, 1'b0, 8'h00, 8'h00, 6'b010000, 9));
`else
    vt.push_back(mk("mul_ff_ff",   OP_MUL,   8'hFF, 8'hFF, 1'b0, 8'h00, 8'h00, 6'b000001, 1));
`endif
    vt.push_back(mk("ill_14",      OP_ILL14, 8'h12, 8'h34, 1'b0, 8'h00, 8'h00, 6'b000001, 1));
    vt.push_back(mk("ill_15",      OP_ILL15, 8'h00, 8'h00, 1'b0, 8'h00, 8'h00, 6'b000001, 1));

    bus.in_valid  = 1'b0;
    bus.op        = '0;
    bus.op1       = '0;
    bus.op2       = '0;
    bus.cin       = 1'b0;
    bus.out_ready = 1'b1;

    // Reset state
    #1 rst_n = 1'b0;
    #15;
    check("reset outputs", observe(), 32'd0);
    check("reset out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cyc();
    check("in_ready after reset", 32'(bus.in_ready), 32'd1);

    // Directed table, back-to-back with out_ready held high
    foreach (vt[i]) begin
      run_op(vt[i].op, vt[i].a, vt[i].b, vt[i].c, obs, lat, rl);
      check({vt[i].name, " result"}, obs, {10'd0, vt[i].hi, vt[i].dout, vt[i].fl});
      check({vt[i].name, " latency"}, 32'(lat), 32'(vt[i].lat));
      check({vt[i].name, " in_ready low cycles"}, 32'(rl), 32'(vt[i].lat - 1));
    end

    // Backpressure: result 0x10 held for 3 cycles while the next op waits
    cyc();
    check("drain out_valid", 32'(bus.out_valid), 32'd0);
    bus.out_ready = 1'b0;
    bus.in_valid  = 1'b1;
    bus.op = OP_ADD; bus.op1 = 8'hF0; bus.op2 = 8'h20; bus.cin = 1'b0;
    cyc();
    bus.op1 = 8'h01; bus.op2 = 8'h02;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp hold%0d dout", k), 32'(bus.dout), 32'h10);
      check($sformatf("bp hold%0d out_valid", k), 32'(bus.out_valid), 32'd1);
      check($sformatf("bp hold%0d in_ready", k), 32'(bus.in_ready), 32'd0);
      cyc();
    end
    bus.out_ready = 1'b1;
    #1;
    check("bp release in_ready", 32'(bus.in_ready), 32'd1);
    cyc();
    bus.in_valid = 1'b0;
    check("bp next result", 32'(bus.dout), 32'h03);
    check("bp next out_valid", 32'(bus.out_valid), 32'd1);
    cyc();
    check("consume drops out_valid", 32'(bus.out_valid), 32'd0);

    // Random ops against the model, with occasional consumer stalls
    for (int i = 0; i < 150; i++) begin
      logic [3:0] ro;
      logic [7:0] ra, rb;
      logic       rc;
      ro = 4'($urandom_range(0, 15));
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      exp = model(ro, int'(ra), int'(rb), int'(rc), mlat);
      run_op(ro, ra, rb, rc, obs, lat, rl);
      check($sformatf("rand%0d op%0d result", i, ro), obs, exp);
      check($sformatf("rand%0d op%0d latency", i, ro), 32'(lat), 32'(mlat));
      if ($urandom_range(0, 3) == 0) begin
        bus.out_ready = 1'b0;
        for (int k = 0; k < int'($urandom_range(1, 3)); k++) begin
          cyc();
          check($sformatf("rand%0d stall result", i), observe(), exp);
          check($sformatf("rand%0d stall in_ready", i), 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
      end
    end

    // Reset in the middle of a SHL by 7
    cyc();
    bus.in_valid = 1'b1;
    bus.op = OP_SHL; bus.op1 = 8'hFF; bus.op2 = 8'h07; bus.cin = 1'b0;
    cyc();
    bus.in_valid = 1'b0;
    cyc();
    cyc();
    check("mid-iter in_ready", 32'(bus.in_ready), 32'd0);
    #2 rst_n = 1'b0;
    #1;
    check("mid-iter reset outputs", observe(), 32'd0);
    check("mid-iter reset out_valid", 32'(bus.out_valid), 32'd0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (bus.out_valid) seen++;
    end
    check("no result after reset", 32'(seen), 32'd0);
    run_op(OP_ADD, 8'h11, 8'h22, 1'b0, obs, lat, rl);
    check("post-reset add", obs, {10'd0, 8'h00, 8'h33, 6'b000000});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
